// File: rtl/maxnet_ctrl.sv
// Sequencing controller for the Maxnet inhibition datapath.
// Loads the neuron bank, issues inhibition iterations until a single neuron
// survives, all neurons die, or the iteration limit is reached, then reports
// the winner and termination cause.
module maxnet_ctrl #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_ITER = 15,
  parameter int unsigned CW       = 4,
  parameter int unsigned WW       = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  nz,
  output logic          ld,
  output logic          upd,
  output logic          busy,
  output logic          done,
  output logic [WW-1:0] winner,
  output logic [CW-1:0] iter_count,
  output logic          timeout,
  output logic          none
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] ITER  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [CW-1:0] IterLimit = CW'(MAX_ITER);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic [WW-1:0] winner_q, winner_d;
  logic          timeout_q, timeout_d;
  logic          none_q, none_d;

  logic [WW:0]   pop;
  logic [WW-1:0] lowest;

  // Population count and lowest set index of the nonzero flags.
  // With exactly one bit set, the lowest index is also the only index.
  always_comb begin
    pop    = '0;
    lowest = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + (WW+1)'(nz[i]);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (nz[i]) lowest = WW'(i);
    end
  end

  // Next-state and result-register update.
  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    winner_d  = winner_q;
    timeout_d = timeout_q;
    none_d    = none_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          iter_d    = '0;
          winner_d  = '0;
          timeout_d = 1'b0;
          none_d    = 1'b0;
        end
      end
      LOAD: state_d = CHECK;
      CHECK: begin
        if (pop == (WW+1)'(1)) begin
          state_d  = DONE;
          winner_d = lowest;
        end else if (nz == '0) begin
          state_d  = DONE;
          none_d   = 1'b1;
          winner_d = '0;
        end else if (iter_q == IterLimit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          winner_d  = lowest;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        state_d = CHECK;
        // CHECK never enters ITER at the limit; the guard just keeps the
        // counter from wrapping should that ever change.
        if (iter_q != IterLimit) iter_d = iter_q + CW'(1);
      end
      DONE: begin
        if (start) begin
          state_d   = LOAD;
          iter_d    = '0;
          winner_d  = '0;
          timeout_d = 1'b0;
          none_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      iter_q    <= '0;
      winner_q  <= '0;
      timeout_q <= 1'b0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      winner_q  <= winner_d;
      timeout_q <= timeout_d;
      none_q    <= none_d;
    end
  end

  // Moore outputs decoded from registered state.
  always_comb begin
    ld         = (state_q == LOAD);
    upd        = (state_q == ITER);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    winner     = winner_q;
    iter_count = iter_q;
    timeout    = timeout_q;
    none       = none_q;
  end

endmodule

// File: doc/maxnet_ctrl.md
Name: maxnet_ctrl

Overview:
- Sequencing controller for the 4-neuron Maxnet inhibition datapath.
- Accepts a start request, then drives the datapath through load and repeated inhibition iterations.
- Watches the datapath's per-neuron nonzero flags and reports the winning neuron index, iteration count and termination cause.
- Sits between the top-level start/Result interface and the Maxnet neuron register bank; the datapath holds no sequencing logic of its own.

Parameters:
- N, 4, number of neurons (nz width).
- MAX_ITER, 15, iteration limit before forced termination.
- CW, 4, iteration counter width; must hold MAX_ITER.
- WW, 2, winner index width, equal to clog2(N).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  run request, sampled on rising clk.
- nz  input  N  per-neuron nonzero flags from datapath; bit i=1 when neuron i register != 0.
- ld  output  1  datapath load strobe: copy a0..a3 into neuron registers.
- upd  output  1  datapath update strobe: apply one inhibition iteration.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- winner  output  WW  index of the winning neuron, held until the next run.
- iter_count  output  CW  number of upd pulses issued in the current or last run.
- timeout  output  1  last run stopped at MAX_ITER with more than one neuron alive.
- none  output  1  last run ended with nz==0 (tie collapse).

Behaviour:
- States: IDLE, LOAD, CHECK, ITER, DONE. Moore outputs, registered state.
- Reset (rst=0, asynchronous): state=IDLE; ld, upd, busy, done, timeout, none = 0; winner=0; iter_count=0.
- IDLE:
  - start=1 -> LOAD.
  - On that edge, clear iter_count, timeout, none and winner.
- LOAD: ld=1 for exactly one cycle -> CHECK.
- CHECK: nz reflects registers written at the previous edge. Evaluate in priority order:
  1. popcount(nz)==1 -> DONE, winner = index of the set bit.
  2. nz==0 -> DONE, none=1, winner=0.
  3. iter_count==MAX_ITER -> DONE, timeout=1, winner = lowest set index of nz.
  4. Otherwise -> ITER.
- ITER: upd=1 for one cycle; iter_count increments on the exiting edge -> CHECK.
- DONE:
  - done=1 for one cycle.
  - start=1 -> LOAD (back-to-back run; flags and counter clear on that edge). Otherwise -> IDLE.
- Latency: start sampled high at edge E0 gives LOAD during E0..E1, CHECK during E1..E2, and DONE during E2..E3 when the first CHECK terminates. Each extra iteration adds 2 cycles, so done appears 3+2k cycles after E0 for k iterations.
- start is ignored in LOAD, CHECK and ITER; no queuing.
- ld and upd are never high together; at most one upd per CHECK.
- iter_count saturates by construction: it never exceeds MAX_ITER.
- winner, timeout, none and iter_count remain stable from DONE until the next accepted start.
- Reset mid-run: immediate return to IDLE with all outputs at reset values; datapath contents are don't-care.
- nz changing while not in CHECK has no effect.

Test Plan:
- Reset: drive rst=0 mid-ITER at iter_count=3 -> same instant busy=0, upd=0, iter_count=0; after rst=1, state stays IDLE with start=0.
- Single winner after 2 iterations: inputs 0,8,3,2; nz after load =1110, after 1st upd =0110, after 2nd upd =0010 -> done at 7 cycles after start edge; winner=1, iter_count=2, timeout=0, none=0; ld seen once, upd seen twice.
- Immediate winner: nz=1000 right after load -> done 3 cycles after start; winner=3, iter_count=0, no upd pulse.
- Tie collapse: nz goes 0011 -> 0000 after 1 upd -> done at cycle 5; none=1, winner=0, iter_count=1.
- Timeout: nz held at 0101 -> exactly 15 upd pulses, done at cycle 33; timeout=1, winner=0, iter_count=15.
- Start handling: start held high through a run -> pulses while busy ignored; start=1 in DONE -> LOAD on the next cycle with iter_count cleared to 0 and outputs of the new run correct.
